// File: rtl/pmod_led_arbiter.sv
// pmod_led_arbiter
// Round-robin arbiter sharing the PMOD LED outputs between NUM_REQ pattern
// sources. Each owner keeps the LEDs for at least HOLD_CYCLES clocks so its
// pattern stays readable. When nobody requests, the LEDs show IDLE_PATTERN.
//
// Ports:
//   clk      in   1              single clock domain
//   reset_   in   1              asynchronous, active-low reset
//   req      in   NUM_REQ        level-sensitive request per source
//   led_in   in   NUM_REQ*LED_W  pattern per source, source i on [i*LED_W +: LED_W]
//   gnt      out  NUM_REQ        one-hot grant, all-zero when idle (registered)
//   led_out  out  LED_W          LED drive (registered, one cycle behind gnt)
//   active   out  1              high while any grant is held (registered)
module pmod_led_arbiter #(
    parameter int                NUM_REQ      = 4,
    parameter int                LED_W        = 4,
    parameter int                HOLD_CYCLES  = 50_000_000,
    parameter logic [LED_W-1:0]  IDLE_PATTERN = {LED_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LED_W-1:0]   led_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [LED_W-1:0]           led_out,
    output logic                       active
);

    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [IDX_W-1:0]    cur_r, cur_nxt_s;
    logic [IDX_W-1:0]    last_r, last_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [NUM_REQ-1:0]  gnt_r, gnt_nxt_s;
    logic                active_r, active_nxt_s;
    logic [LED_W-1:0]    led_out_r;

    logic [IDX_W-1:0]    win_s;
    logic                any_req_s;
    logic                others_s;
    logic                expired_s;
    logic [LED_W-1:0]    led_arr_s [NUM_REQ];

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = {NUM_REQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Split the flat pattern bus into one slice per source.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_led_split
        assign led_arr_s[g] = led_in[g*LED_W +: LED_W];
    end

    assign any_req_s = |req;
    // Requests from anyone except the current owner decide a handover at expiry.
    assign others_s  = |(req & ~onehot(cur_r));
    assign expired_s = (cnt_r == HOLD_LAST);

    // Round-robin winner: scan last+1 .. last (wrapping), first requester wins.
    always_comb begin
        logic found;
        int   idx;
        win_s = last_r;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_r) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                win_s = IDX_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (expired_s && !any_req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values of grant, owner, pointer, counter.
    always_comb begin
        gnt_nxt_s    = gnt_r;
        cur_nxt_s    = cur_r;
        last_nxt_s   = last_r;
        cnt_nxt_s    = cnt_r;
        active_nxt_s = active_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    gnt_nxt_s    = onehot(win_s);
                    cur_nxt_s    = win_s;
                    last_nxt_s   = win_s;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    active_nxt_s = 1'b1;
                end else begin
                    gnt_nxt_s    = {NUM_REQ{1'b0}};
                    active_nxt_s = 1'b0;
                end
            end
            HOLD: begin
                if (!expired_s) begin
                    // Minimum hold: no early release, no preemption.
                    cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                end else if (others_s) begin
                    // Direct handover without an idle cycle.
                    gnt_nxt_s  = onehot(win_s);
                    cur_nxt_s  = win_s;
                    last_nxt_s = win_s;
                    cnt_nxt_s  = {CNT_W{1'b0}};
                end else if (req[cur_r]) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    gnt_nxt_s    = {NUM_REQ{1'b0}};
                    active_nxt_s = 1'b0;
                end
            end
            default: begin
                gnt_nxt_s    = {NUM_REQ{1'b0}};
                active_nxt_s = 1'b0;
            end
        endcase
    end

    // Grant, owner, round-robin pointer and hold counter registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            gnt_r    <= {NUM_REQ{1'b0}};
            cur_r    <= {IDX_W{1'b0}};
            last_r   <= IDX_W'(NUM_REQ - 1);
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= 1'b0;
        end else begin
            gnt_r    <= gnt_nxt_s;
            cur_r    <= cur_nxt_s;
            last_r   <= last_nxt_s;
            cnt_r    <= cnt_nxt_s;
            active_r <= active_nxt_s;
        end
    end

    // LED register: follows the registered grant, so it lags gnt by one cycle.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            led_out_r <= IDLE_PATTERN;
        end else if (gnt_r != {NUM_REQ{1'b0}}) begin
            led_out_r <= led_arr_s[cur_r];
        end else begin
            led_out_r <= IDLE_PATTERN;
        end
    end

    assign gnt     = gnt_r;
    assign led_out = led_out_r;
    assign active  = active_r;

endmodule

// File: tb/tb_pmod_led_arbiter.sv
// Directed testbench for pmod_led_arbiter with HOLD_CYCLES=4, NUM_REQ=4 and
// source i driving the constant pattern i+1.
module tb_pmod_led_arbiter;

    logic        clk;
    logic        reset_;
    logic [3:0]  req;
    logic [15:0] led_in;
    logic [3:0]  gnt;
    logic [3:0]  led_out;
    logic        active;

    int n_checks;
    int n_fail;

    pmod_led_arbiter #(
        .NUM_REQ      (4),
        .LED_W        (4),
        .HOLD_CYCLES  (4),
        .IDLE_PATTERN (4'b0000)
    ) dut (
        .clk     (clk),
        .reset_  (reset_),
        .req     (req),
        .led_in  (led_in),
        .gnt     (gnt),
        .led_out (led_out),
        .active  (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; the first edge after this returns is active.
    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        #2;
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        req      = 4'b0000;
        led_in   = {4'h4, 4'h3, 4'h2, 4'h1};
        reset_   = 1'b0;

        // Reset state
        #3;
        check_eq("rst_gnt", {28'd0, gnt}, 32'h0);
        check_eq("rst_active", {31'd0, active}, 32'h0);
        check_eq("rst_led", {28'd0, led_out}, 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        // Single request from idle, indefinite hold, then release
        req = 4'b0010;
        tick();
        check_eq("single_gnt", {28'd0, gnt}, 32'h2);
        check_eq("single_active", {31'd0, active}, 32'h1);
        check_eq("single_led_lag", {28'd0, led_out}, 32'h0);
        tick();
        check_eq("single_led", {28'd0, led_out}, 32'h2);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("single_hold_gnt", {28'd0, gnt}, 32'h2);
            check_eq("single_hold_led", {28'd0, led_out}, 32'h2);
        end
        req = 4'b0000;
        tick();
        check_eq("release_gnt", {28'd0, gnt}, 32'h0);
        check_eq("release_active", {31'd0, active}, 32'h0);
        check_eq("release_led_lag", {28'd0, led_out}, 32'h2);
        tick();
        check_eq("release_led", {28'd0, led_out}, 32'h0);

        // Early drop: one-cycle request still holds for 4 cycles
        req = 4'b0100;
        tick();
        check_eq("drop_gnt0", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("drop_gnt_hold", {28'd0, gnt}, 32'h4);
            check_eq("drop_active", {31'd0, active}, 32'h1);
        end
        tick();
        check_eq("drop_gnt_end", {28'd0, gnt}, 32'h0);
        check_eq("drop_active_end", {31'd0, active}, 32'h0);
        check_eq("drop_led_lag", {28'd0, led_out}, 32'h3);
        tick();
        check_eq("drop_led_idle", {28'd0, led_out}, 32'h0);

        // Asynchronous reset in the middle of a grant
        req = 4'b1111;
        tick();
        tick();
        check_eq("pre_rst_gnt", {28'd0, gnt}, 32'h8);
        check_eq("pre_rst_led", {28'd0, led_out}, 32'h4);
        #2;
        reset_ = 1'b0;
        #1;
        check_eq("async_rst_gnt", {28'd0, gnt}, 32'h0);
        check_eq("async_rst_active", {31'd0, active}, 32'h0);
        check_eq("async_rst_led", {28'd0, led_out}, 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        // Full contention from reset: each owner exactly 4 cycles, rotating from 0
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("rr_gnt", {28'd0, gnt}, 32'd1 << ((k / 4) % 4));
            check_eq("rr_active", {31'd0, active}, 32'h1);
            if (k == 0) begin
                check_eq("rr_led", {28'd0, led_out}, 32'h0);
            end else begin
                check_eq("rr_led", {28'd0, led_out}, 32'(((k - 1) / 4) % 4 + 1));
            end
        end

        // Simultaneous handover at expiry: 0001 -> 1000 with no idle cycle
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("hand_gnt_owner0", {28'd0, gnt}, 32'h1);
        end
        req = 4'b1000;
        tick();
        check_eq("hand_gnt_new", {28'd0, gnt}, 32'h8);
        check_eq("hand_active", {31'd0, active}, 32'h1);
        check_eq("hand_led_lag", {28'd0, led_out}, 32'h1);
        tick();
        check_eq("hand_led_new", {28'd0, led_out}, 32'h4);

        // Owner-only stays: a short pulse on req[2] during the hold is ignored
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0101;
        tick();
        req = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("stay_gnt", {28'd0, gnt}, 32'h1);
            check_eq("stay_led", {28'd0, led_out}, 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
